// File: rtl/zap_cache_tag_ram_wb_pkg.sv
// Shared encodings for the ZAP L1 tag/data store: Wishbone cycle types,
// maintenance op codes and the maintenance FSM states.
package zap_cache_tag_ram_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_BURST   = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        MAINT_NOP       = 2'b00,
        MAINT_CLEAN     = 2'b01,
        MAINT_INV       = 2'b10,
        MAINT_CLEAN_INV = 2'b11
    } maint_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN_RD,
        S_SCAN_CHK,
        S_WB_BURST,
        S_LINE_DONE,
        S_FIN
    } state_t;

endpackage

// File: rtl/zap_cache_line_burst_wr.sv
// Writes one cache line to memory as a registered Wishbone incrementing
// burst of BEATS words; o_done marks the acknowledge of the final beat.
module zap_cache_line_burst_wr
    import zap_cache_tag_ram_wb_pkg::*;
#(
    parameter int unsigned BEATS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [32*BEATS-1:0]   i_line,
    input  logic [31:0]           i_base_adr,
    input  logic                  i_wb_ack,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_wen,
    output logic [31:0]           o_wb_adr,
    output logic [31:0]           o_wb_dat,
    output logic [3:0]            o_wb_sel,
    output logic [2:0]            o_wb_cti,
    output logic                  o_done
);

    localparam int unsigned BW = $clog2(BEATS);

    logic [32*BEATS-1:0] r_line;
    logic [BW-1:0]       r_beat;
    logic [BW-1:0]       w_beat_nxt;
    logic                w_last;

    assign w_beat_nxt = r_beat + BW'(1);
    assign w_last     = (r_beat == BW'(BEATS - 1));
    assign o_done     = o_wb_stb & i_wb_ack & w_last;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_wen <= 1'b0;
            o_wb_adr <= '0;
            o_wb_dat <= '0;
            o_wb_sel <= '0;
            o_wb_cti <= CTI_CLASSIC;
            r_beat   <= '0;
            r_line   <= '0;
        end else if (i_start) begin
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            o_wb_wen <= 1'b1;
            o_wb_sel <= 4'hF;
            o_wb_adr <= i_base_adr;
            o_wb_dat <= i_line[31:0];
            o_wb_cti <= (BEATS > 1) ? CTI_BURST : CTI_EOB;
            r_line   <= i_line;
            r_beat   <= '0;
        end else if (o_wb_stb && i_wb_ack) begin
            if (w_last) begin
                o_wb_cyc <= 1'b0;
                o_wb_stb <= 1'b0;
                o_wb_wen <= 1'b0;
                o_wb_sel <= '0;
                o_wb_cti <= CTI_CLASSIC;
            end else begin
                // Next beat is staged here so it is visible the cycle after the ack.
                r_beat   <= w_beat_nxt;
                o_wb_adr <= o_wb_adr + 32'd4;
                o_wb_dat <= r_line[32*w_beat_nxt +: 32];
                o_wb_cti <= (w_beat_nxt == BW'(BEATS - 1)) ? CTI_EOB : CTI_BURST;
            end
        end
    end

endmodule

// File: rtl/zap_cache_tag_ram_wb.sv
// Direct-mapped tag/data/valid/dirty store with a maintenance scanner that
// cleans and/or invalidates every line, writing dirty lines back over Wishbone.
module zap_cache_tag_ram_wb
    import zap_cache_tag_ram_wb_pkg::*;
#(
    parameter  int unsigned CACHE_SIZE = 1024,
    parameter  int unsigned LINE_BYTES = 16,
    localparam int unsigned OFS_W      = $clog2(LINE_BYTES),
    localparam int unsigned TAG_W      = 32 - OFS_W
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [31:0]             i_address_nxt,
    input  logic [31:0]             i_address,
    input  logic                    i_cache_en,
    input  logic [8*LINE_BYTES-1:0] i_cache_line,
    input  logic [LINE_BYTES-1:0]   i_cache_line_ben,
    output logic [8*LINE_BYTES-1:0] o_cache_line,
    input  logic                    i_cache_tag_wr_en,
    input  logic [TAG_W-1:0]        i_cache_tag,
    input  logic                    i_cache_tag_dirty,
    output logic [TAG_W-1:0]        o_cache_tag,
    output logic                    o_cache_tag_valid,
    output logic                    o_cache_tag_dirty,
    input  logic                    i_maint_req,
    input  logic [1:0]              i_maint_op,
    output logic                    o_maint_done,
    output logic                    o_busy,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_wen,
    output logic [31:0]             o_wb_adr,
    output logic [31:0]             o_wb_dat,
    output logic [3:0]              o_wb_sel,
    output logic [2:0]              o_wb_cti,
    input  logic                    i_wb_ack
);

    localparam int unsigned LINES = CACHE_SIZE / LINE_BYTES;
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned BEATS = LINE_BYTES / 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

    logic [8*LINE_BYTES-1:0] r_data [LINES];
    logic [TAG_W-1:0]        r_tag  [LINES];
    logic [LINES-1:0]        r_valid;
    logic [LINES-1:0]        r_dirty;

    state_t          r_state;
    state_t          w_state_nxt;
    maint_op_t       r_op;
    logic [IDX_W-1:0] r_cnt;
    logic            r_done;
    logic            w_idle;
    logic            w_burst_start;
    logic            w_burst_done;
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic            w_unused;

    assign w_idle       = (r_state == S_IDLE);
    assign w_wr_idx     = i_address[OFS_W+IDX_W-1:OFS_W];
    assign w_rd_idx     = w_idle ? i_address_nxt[OFS_W+IDX_W-1:OFS_W] : r_cnt;
    assign o_busy       = !w_idle;
    assign o_maint_done = r_done;
    assign w_unused     = ^{i_address, i_address_nxt};

    // Array storage is deliberately left unreset; only valid/dirty gate hits.
    always_ff @(posedge i_clk) begin
        if (w_idle) begin
            for (int unsigned b = 0; b < LINE_BYTES; b++) begin
                if (i_cache_line_ben[b])
                    r_data[w_wr_idx][8*b +: 8] <= i_cache_line[8*b +: 8];
            end
            if (i_cache_tag_wr_en)
                r_tag[w_wr_idx] <= i_cache_tag;
        end
        o_cache_line <= r_data[w_rd_idx];
        o_cache_tag  <= r_tag[w_rd_idx];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid           <= '0;
            r_dirty           <= '0;
            o_cache_tag_valid <= 1'b0;
            o_cache_tag_dirty <= 1'b0;
        end else begin
            o_cache_tag_valid <= r_valid[w_rd_idx];
            o_cache_tag_dirty <= r_dirty[w_rd_idx];
            if (!i_cache_en) begin
                r_valid <= '0;
                r_dirty <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (i_cache_tag_wr_en) begin
                        r_valid[w_wr_idx] <= 1'b1;
                        r_dirty[w_wr_idx] <= i_cache_tag_dirty;
                    end
                    S_LINE_DONE: begin
                        r_dirty[r_cnt] <= 1'b0;
                        if (r_op[1]) r_valid[r_cnt] <= 1'b0;
                    end
                    S_FIN: if (r_op == MAINT_INV) r_valid <= '0;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_op    <= MAINT_NOP;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == S_FIN) ||
                       (w_idle && i_maint_req && maint_op_t'(i_maint_op) == MAINT_NOP);
            if (w_idle && i_maint_req) begin
                r_op  <= maint_op_t'(i_maint_op);
                r_cnt <= '0;
            end else if (r_state == S_LINE_DONE && r_cnt != LAST_IDX) begin
                r_cnt <= r_cnt + IDX_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_burst_start = 1'b0;
        case (r_state)
            S_IDLE:
                if (i_maint_req && maint_op_t'(i_maint_op) != MAINT_NOP)
                    w_state_nxt = S_SCAN_RD;
            S_SCAN_RD:
                w_state_nxt = S_SCAN_CHK;
            S_SCAN_CHK:
                if (r_op[0] && o_cache_tag_valid && o_cache_tag_dirty) begin
                    w_state_nxt   = S_WB_BURST;
                    w_burst_start = 1'b1;
                end else begin
                    w_state_nxt = S_LINE_DONE;
                end
            S_WB_BURST:
                if (w_burst_done) w_state_nxt = S_LINE_DONE;
            S_LINE_DONE:
                w_state_nxt = (r_cnt == LAST_IDX) ? S_FIN : S_SCAN_RD;
            S_FIN:
                w_state_nxt = S_IDLE;
            default:
                w_state_nxt = S_IDLE;
        endcase
    end

    zap_cache_line_burst_wr #(
        .BEATS (BEATS)
    ) u_burst (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (w_burst_start),
        .i_line     (o_cache_line),
        .i_base_adr ({o_cache_tag, {OFS_W{1'b0}}}),
        .i_wb_ack   (i_wb_ack),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_wen   (o_wb_wen),
        .o_wb_adr   (o_wb_adr),
        .o_wb_dat   (o_wb_dat),
        .o_wb_sel   (o_wb_sel),
        .o_wb_cti   (o_wb_cti),
        .o_done     (w_burst_done)
    );

endmodule

// File: tb/tb_zap_cache_tag_ram_wb.sv
// Directed bench for zap_cache_tag_ram_wb with 32-byte lines and 8 lines:
// fill, clean (with and without ack stalls), invalidate, clean+invalidate, reset mid-burst.
module tb_zap_cache_tag_ram_wb;

    localparam int unsigned CS    = 256;
    localparam int unsigned LB    = 32;
    localparam int unsigned LINES = CS / LB;
    localparam int unsigned BEATS = LB / 4;
    localparam int unsigned TAG_W = 27;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic [31:0]       i_address_nxt;
    logic [31:0]       i_address;
    logic              i_cache_en;
    logic [8*LB-1:0]   i_cache_line;
    logic [LB-1:0]     i_cache_line_ben;
    logic [8*LB-1:0]   o_cache_line;
    logic              i_cache_tag_wr_en;
    logic [TAG_W-1:0]  i_cache_tag;
    logic              i_cache_tag_dirty;
    logic [TAG_W-1:0]  o_cache_tag;
    logic              o_cache_tag_valid;
    logic              o_cache_tag_dirty;
    logic              i_maint_req;
    logic [1:0]        i_maint_op;
    logic              o_maint_done;
    logic              o_busy;
    logic              o_wb_cyc, o_wb_stb, o_wb_wen;
    logic [31:0]       o_wb_adr, o_wb_dat;
    logic [3:0]        o_wb_sel;
    logic [2:0]        o_wb_cti;
    logic              i_wb_ack;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_w [BEATS];

    localparam logic [TAG_W-1:0] T_MAIN = 27'h123453;
    localparam logic [31:0]      B_MAIN = 32'h02468A60;

    always #5 i_clk = ~i_clk;

    zap_cache_tag_ram_wb #(
        .CACHE_SIZE (CS),
        .LINE_BYTES (LB)
    ) dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_address_nxt     (i_address_nxt),
        .i_address         (i_address),
        .i_cache_en        (i_cache_en),
        .i_cache_line      (i_cache_line),
        .i_cache_line_ben  (i_cache_line_ben),
        .o_cache_line      (o_cache_line),
        .i_cache_tag_wr_en (i_cache_tag_wr_en),
        .i_cache_tag       (i_cache_tag),
        .i_cache_tag_dirty (i_cache_tag_dirty),
        .o_cache_tag       (o_cache_tag),
        .o_cache_tag_valid (o_cache_tag_valid),
        .o_cache_tag_dirty (o_cache_tag_dirty),
        .i_maint_req       (i_maint_req),
        .i_maint_op        (i_maint_op),
        .o_maint_done      (o_maint_done),
        .o_busy            (o_busy),
        .o_wb_cyc          (o_wb_cyc),
        .o_wb_stb          (o_wb_stb),
        .o_wb_wen          (o_wb_wen),
        .o_wb_adr          (o_wb_adr),
        .o_wb_dat          (o_wb_dat),
        .o_wb_sel          (o_wb_sel),
        .o_wb_cti          (o_wb_cti),
        .i_wb_ack          (i_wb_ack)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Tag write (optionally with full line data) to one index, one cycle.
    task automatic wr_line(input int idx, input logic [TAG_W-1:0] tag, input logic dirty,
                           input logic data_en);
        i_address         = 32'(idx << 5);
        i_cache_tag       = tag;
        i_cache_tag_dirty = dirty;
        i_cache_tag_wr_en = 1'b1;
        for (int k = 0; k < int'(BEATS); k++) i_cache_line[32*k +: 32] = exp_w[k];
        i_cache_line_ben  = data_en ? '1 : '0;
        @(negedge i_clk);
        i_cache_tag_wr_en = 1'b0;
        i_cache_line_ben  = '0;
    endtask

    task automatic rd_chk(input string tag, input int idx, input logic v, input logic d);
        i_address_nxt = 32'(idx << 5);
        @(negedge i_clk);
        chk({tag, "_valid"}, 64'(o_cache_tag_valid), 64'(v));
        chk({tag, "_dirty"}, 64'(o_cache_tag_dirty), 64'(d));
    endtask

    // Issues one maintenance op and plays the Wishbone slave, checking each beat.
    task automatic run_maint(input logic [1:0] op, input int stall_beat, input logic [31:0] base,
                             output int beats, output int dones, output int cycles);
        int stall;
        logic [31:0] s_adr, s_dat;
        logic [2:0]  s_cti;
        beats = 0; dones = 0; cycles = 0; stall = 0;
        s_adr = '0; s_dat = '0; s_cti = '0;
        i_maint_req = 1'b1;
        i_maint_op  = op;
        @(negedge i_clk);
        i_maint_req = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            i_wb_ack = 1'b0;
            if (o_maint_done) begin
                dones  = 1;
                cycles = c;
                break;
            end
            if (o_wb_stb) begin
                if (beats >= int'(BEATS)) begin
                    chk("extra_beat", 64'(beats), 64'(BEATS - 1));
                    i_wb_ack = 1'b1;
                end else if (beats == stall_beat && stall < 5) begin
                    if (stall > 0) begin
                        chk("stall_adr", 64'(o_wb_adr), 64'(s_adr));
                        chk("stall_dat", 64'(o_wb_dat), 64'(s_dat));
                        chk("stall_cti", 64'(o_wb_cti), 64'(s_cti));
                    end
                    s_adr = o_wb_adr; s_dat = o_wb_dat; s_cti = o_wb_cti;
                    stall++;
                end else begin
                    chk("beat_adr", 64'(o_wb_adr), 64'(base + 32'(4 * beats)));
                    chk("beat_dat", 64'(o_wb_dat), 64'(exp_w[beats]));
                    chk("beat_cti", 64'(o_wb_cti),
                        (beats == int'(BEATS) - 1) ? 64'h7 : 64'h2);
                    chk("beat_ctl", 64'({o_wb_cyc, o_wb_wen, o_wb_sel}), 64'h3F);
                    i_wb_ack = 1'b1;
                    beats++;
                end
            end
            @(negedge i_clk);
        end
        i_wb_ack = 1'b0;
    endtask

    initial begin
        int beats, dones, cycles, seen;
        logic hit;
        i_reset = 1'b1; i_address_nxt = '0; i_address = '0; i_cache_en = 1'b1;
        i_cache_line = '0; i_cache_line_ben = '0; i_cache_tag_wr_en = 1'b0;
        i_cache_tag = '0; i_cache_tag_dirty = 1'b0; i_maint_req = 1'b0;
        i_maint_op = 2'b00; i_wb_ack = 1'b0;
        for (int k = 0; k < int'(BEATS); k++) exp_w[k] = 32'hA0B0C000 + 32'(k);
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;

        // Reset state, reading index 5.
        rd_chk("rst_idx5", 5, 1'b0, 1'b0);
        chk("rst_wb_ctl", 64'({o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel, o_wb_cti}), 64'h0);
        chk("rst_wb_adr", 64'(o_wb_adr), 64'h0);
        chk("rst_wb_dat", 64'(o_wb_dat), 64'h0);
        chk("rst_done_busy", 64'({o_maint_done, o_busy}), 64'h0);

        // Fill index 3 while reading it in the same cycle: old contents come back.
        i_address_nxt = 32'h60;
        wr_line(3, T_MAIN, 1'b1, 1'b1);
        chk("rw_same_old_valid", 64'(o_cache_tag_valid), 64'h0);
        @(negedge i_clk);
        chk("fill_tag", 64'(o_cache_tag), 64'(T_MAIN));
        chk("fill_vd", 64'({o_cache_tag_valid, o_cache_tag_dirty}), 64'h3);
        chk("fill_w0", 64'(o_cache_line[31:0]), 64'(exp_w[0]));
        chk("fill_w7", 64'(o_cache_line[255:224]), 64'(exp_w[7]));

        // Clean: one 8-beat burst, line stays valid but clean.
        run_maint(2'b01, -1, B_MAIN, beats, dones, cycles);
        chk("clean_beats", 64'(beats), 64'(BEATS));
        chk("clean_done", 64'(dones), 64'h1);
        @(negedge i_clk);
        chk("clean_done_pulse_len", 64'(o_maint_done), 64'h0);
        rd_chk("clean_idx3", 3, 1'b1, 1'b0);

        // Clean with ack held low for five cycles on beat 2.
        wr_line(3, T_MAIN, 1'b1, 1'b0);
        run_maint(2'b01, 2, B_MAIN, beats, dones, cycles);
        chk("stall_beats", 64'(beats), 64'(BEATS));
        chk("stall_done", 64'(dones), 64'h1);
        @(negedge i_clk);

        // No-op request completes immediately.
        i_maint_req = 1'b1; i_maint_op = 2'b00;
        @(negedge i_clk);
        i_maint_req = 1'b0;
        chk("nop_done_busy", 64'({o_maint_done, o_busy}), 64'h2);

        // Invalidate with dirty lines 0 and 7: no write-back, everything invalid.
        wr_line(0, 27'h10, 1'b1, 1'b0);
        wr_line(7, 27'h20, 1'b1, 1'b0);
        run_maint(2'b10, -1, 32'h0, beats, dones, cycles);
        chk("inv_beats", 64'(beats), 64'h0);
        chk("inv_done", 64'(dones), 64'h1);
        chk("inv_latency", 64'(cycles > int'(LINES)), 64'h1);
        rd_chk("inv_idx0", 0, 1'b0, 1'b0);
        rd_chk("inv_idx7", 7, 1'b0, 1'b0);
        rd_chk("inv_idx3", 3, 1'b0, 1'b0);

        // Clean+invalidate: dirty index 3 written back, clean index 5 just dropped.
        wr_line(3, T_MAIN, 1'b1, 1'b0);
        wr_line(5, 27'h55, 1'b0, 1'b0);
        run_maint(2'b11, -1, B_MAIN, beats, dones, cycles);
        chk("ci_beats", 64'(beats), 64'(BEATS));
        chk("ci_done", 64'(dones), 64'h1);
        rd_chk("ci_idx3", 3, 1'b0, 1'b0);
        rd_chk("ci_idx5", 5, 1'b0, 1'b0);

        // Cache disable wipes valid bits.
        wr_line(2, 27'h77, 1'b0, 1'b0);
        rd_chk("en_before", 2, 1'b1, 1'b0);
        i_cache_en = 1'b0;
        @(negedge i_clk);
        i_cache_en = 1'b1;
        rd_chk("en_after", 2, 1'b0, 1'b0);

        // Reset during beat 1 of a clean burst.
        wr_line(3, T_MAIN, 1'b1, 1'b0);
        seen = 0; hit = 1'b0;
        i_maint_req = 1'b1; i_maint_op = 2'b01;
        @(negedge i_clk);
        i_maint_req = 1'b0;
        for (int c = 0; c < 200; c++) begin
            i_wb_ack = 1'b0;
            if (o_wb_stb) begin
                if (seen == 1) begin
                    hit = 1'b1;
                    break;
                end
                i_wb_ack = 1'b1;
                seen++;
            end
            @(negedge i_clk);
        end
        chk("rst_mid_reach_beat1", 64'(hit), 64'h1);
        chk("rst_mid_beat1_adr", 64'(o_wb_adr), 64'(B_MAIN + 32'd4));
        i_reset = 1'b1;
        @(negedge i_clk);
        chk("rst_mid_cyc_stb", 64'({o_wb_cyc, o_wb_stb}), 64'h0);
        chk("rst_mid_busy_done", 64'({o_busy, o_maint_done}), 64'h0);
        i_reset = 1'b0;
        run_maint(2'b01, -1, B_MAIN, beats, dones, cycles);
        chk("post_rst_beats", 64'(beats), 64'h0);
        chk("post_rst_done", 64'(dones), 64'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
